// File: rtl/bram_arb_pkg.sv
// Shared constants and the round-robin pick helper for the BRAM port arbiter.
package bram_arb_pkg;

    localparam int ADDR_WIDTH_DEF = 11;
    localparam int DATA_WIDTH_DEF = 192;

    // Widest requester set the pick helper handles, and index/count widths for it.
    localparam int RR_MAX_N = 32;
    localparam int RR_IDX_W = 5;
    localparam int RR_CNT_W = 6;

    // Pointer width for an N-way arbiter; a single requester still gets a 1-bit pointer.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One-hot pick of the first valid requester, searching from ptr upward and wrapping at n-1.
    function automatic logic [RR_MAX_N-1:0] rr_pick(
        input logic [RR_MAX_N-1:0] valid,
        input logic [RR_IDX_W-1:0] ptr,
        input logic [RR_CNT_W-1:0] n
    );
        logic [RR_MAX_N-1:0] grant;
        logic                found;
        logic [RR_CNT_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < RR_MAX_N; k++) begin
            idx = {1'b0, ptr} + RR_CNT_W'(k);
            if (idx >= n) begin
                idx = idx - n;
            end else begin
                idx = idx;
            end
            if (!found && (RR_CNT_W'(k) < n) && valid[idx[RR_IDX_W-1:0]]) begin
                grant[idx[RR_IDX_W-1:0]] = 1'b1;
                found                    = 1'b1;
            end else begin
                found = found;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// N-way round-robin arbiter: picks one requester from the pointer and reports the advanced pointer.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter  int N     = 4,
    localparam int PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     valid_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] next_ptr_o
);

    // Grant the first valid requester at or after the pointer; the pointer moves just past the winner.
    always_comb begin
        grant_o    = N'(rr_pick(RR_MAX_N'(valid_i), RR_IDX_W'(ptr_i), RR_CNT_W'(N)));
        next_ptr_o = ptr_i;
        for (int i = 0; i < N; i++) begin
            if (grant_o[i]) begin
                next_ptr_o = (i == N - 1) ? '0 : PTR_W'(i + 1);
            end else begin
                next_ptr_o = next_ptr_o;
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one simple-dual-port BRAM between several read and write requesters.
// Each port is arbitrated round-robin on its own; a read that collides with the
// same-cycle write address is held off one cycle so it returns the new data.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter  int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int NUM_RD     = 4,
    parameter  int NUM_WR     = 2,
    parameter  int RD_LATENCY = 1,
    localparam int RD_PTR_W   = ptr_width(NUM_RD),
    localparam int WR_PTR_W   = ptr_width(NUM_WR)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD-1:0]            rd_req_valid_i,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_req_addr_i,
    output logic [NUM_RD-1:0]            rd_req_ready_o,
    output logic [NUM_RD-1:0]            rd_rsp_valid_o,
    output logic [DATA_WIDTH-1:0]        rd_rsp_data_o,
    input  logic [NUM_WR-1:0]            wr_req_valid_i,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_req_addr_i,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_req_data_i,
    output logic [NUM_WR-1:0]            wr_req_ready_o,
    output logic                         bram_re_o,
    output logic [ADDR_WIDTH-1:0]        bram_rd_addr_o,
    input  logic [DATA_WIDTH-1:0]        bram_rd_data_i,
    output logic                         bram_we_o,
    output logic [ADDR_WIDTH-1:0]        bram_wr_addr_o,
    output logic [DATA_WIDTH-1:0]        bram_wr_data_o
);

    logic [RD_PTR_W-1:0]   rd_ptr_q;
    logic [RD_PTR_W-1:0]   rd_ptr_d;
    logic [RD_PTR_W-1:0]   rd_next_ptr_s;
    logic [WR_PTR_W-1:0]   wr_ptr_q;
    logic [WR_PTR_W-1:0]   wr_ptr_d;
    logic [WR_PTR_W-1:0]   wr_next_ptr_s;
    logic [NUM_RD-1:0]     rd_valid_s;
    logic [NUM_WR-1:0]     wr_valid_s;
    logic [NUM_RD-1:0]     rd_cand_s;
    logic [NUM_RD-1:0]     rd_grant_s;
    logic [NUM_WR-1:0]     wr_grant_s;
    logic [ADDR_WIDTH-1:0] rd_cand_addr_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic                  hazard_s;
    logic [NUM_RD-1:0]     id_pipe_q [RD_LATENCY];

    // Requests are masked while reset is asserted so no grant or BRAM strobe can escape.
    always_comb begin
        if (rst_n) begin
            rd_valid_s = rd_req_valid_i;
            wr_valid_s = wr_req_valid_i;
        end else begin
            rd_valid_s = '0;
            wr_valid_s = '0;
        end
    end

    rr_arbiter #(.N(NUM_RD)) u_rd_arb (
        .valid_i    (rd_valid_s),
        .ptr_i      (rd_ptr_q),
        .grant_o    (rd_cand_s),
        .next_ptr_o (rd_next_ptr_s)
    );

    rr_arbiter #(.N(NUM_WR)) u_wr_arb (
        .valid_i    (wr_valid_s),
        .ptr_i      (wr_ptr_q),
        .grant_o    (wr_grant_s),
        .next_ptr_o (wr_next_ptr_s)
    );

    // One-hot muxes: the winning read address and the winning write address/data (zero when idle).
    always_comb begin
        rd_cand_addr_s = '0;
        wr_addr_s      = '0;
        wr_data_s      = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_cand_addr_s |= {ADDR_WIDTH{rd_cand_s[i]}} & rd_req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
        for (int j = 0; j < NUM_WR; j++) begin
            wr_addr_s |= {ADDR_WIDTH{wr_grant_s[j]}} & wr_req_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
            wr_data_s |= {DATA_WIDTH{wr_grant_s[j]}} & wr_req_data_i[j*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Same-address collision: the BRAM is read-first, so defer the read and keep its pointer.
    always_comb begin
        hazard_s = (|rd_cand_s) && (|wr_grant_s) && (rd_cand_addr_s == wr_addr_s);
        if (hazard_s) begin
            rd_grant_s = '0;
            rd_ptr_d   = rd_ptr_q;
        end else begin
            rd_grant_s = rd_cand_s;
            rd_ptr_d   = rd_next_ptr_s;
        end
        wr_ptr_d = wr_next_ptr_s;
    end

    // Drive handshakes and both BRAM ports straight from the grants.
    always_comb begin
        rd_req_ready_o = rd_grant_s;
        wr_req_ready_o = wr_grant_s;
        bram_re_o      = |rd_grant_s;
        bram_we_o      = |wr_grant_s;
        bram_wr_addr_o = wr_addr_s;
        bram_wr_data_o = wr_data_s;
        if (hazard_s) begin
            bram_rd_addr_o = '0;
        end else begin
            bram_rd_addr_o = rd_cand_addr_s;
        end
    end

    // Round-robin pointers and the grant-id pipe that tags returning read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                id_pipe_q[s] <= '0;
            end
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            id_pipe_q[0] <= rd_grant_s;
            for (int s = 1; s < RD_LATENCY; s++) begin
                id_pipe_q[s] <= id_pipe_q[s-1];
            end
        end
    end

    assign rd_rsp_valid_o = id_pipe_q[RD_LATENCY-1];
    assign rd_rsp_data_o  = bram_rd_data_i;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a read-first BRAM model and a response scoreboard.
module tb_bram_port_arbiter;

    localparam int AW  = 11;
    localparam int DW  = 192;
    localparam int NR  = 4;
    localparam int NW  = 2;
    localparam int LAT = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   rd_valid;
    logic [NR*AW-1:0] rd_addr;
    logic [NR-1:0]   rd_ready;
    logic [NR-1:0]   rd_rsp_valid;
    logic [DW-1:0]   rd_rsp_data;
    logic [NW-1:0]   wr_valid;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic [NW-1:0]   wr_ready;
    logic            bram_re;
    logic [AW-1:0]   bram_rd_addr;
    logic [DW-1:0]   bram_rd_data = '0;
    logic            bram_we;
    logic [AW-1:0]   bram_wr_addr;
    logic [DW-1:0]   bram_wr_data;

    logic [DW-1:0]   mem [0:2047];
    logic            pl_en = 1'b0;
    logic [AW-1:0]   pl_addr = '0;
    logic [DW-1:0]   pl_data = '0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int            due;
        logic [NR-1:0] oh;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb_q[$];

    bram_port_arbiter #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NUM_RD (NR), .NUM_WR (NW), .RD_LATENCY (LAT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rd_req_valid_i (rd_valid),
        .rd_req_addr_i  (rd_addr),
        .rd_req_ready_o (rd_ready),
        .rd_rsp_valid_o (rd_rsp_valid),
        .rd_rsp_data_o  (rd_rsp_data),
        .wr_req_valid_i (wr_valid),
        .wr_req_addr_i  (wr_addr),
        .wr_req_data_i  (wr_data),
        .wr_req_ready_o (wr_ready),
        .bram_re_o      (bram_re),
        .bram_rd_addr_o (bram_rd_addr),
        .bram_rd_data_i (bram_rd_data),
        .bram_we_o      (bram_we),
        .bram_wr_addr_o (bram_wr_addr),
        .bram_wr_data_o (bram_wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read-first BRAM, one cycle read latency, plus a bench preload port.
    always @(posedge clk) begin
        if (bram_re) bram_rd_data <= mem[bram_rd_addr];
        if (bram_we) mem[bram_wr_addr] <= bram_wr_data;
        if (pl_en)   mem[pl_addr] <= pl_data;
    end

    function automatic logic [DW-1:0] pat(input int a);
        return {64'(a) ^ 64'hDEAD_BEEF_0000_0000, 64'h0123_4567_89AB_CDEF, 64'(a)};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input logic [NR-1:0] oh, input logic [DW-1:0] d);
        sb_q.push_back('{due: cyc + LAT, oh: oh, data: d});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a);
        rd_addr[i*AW +: AW] = a;
    endtask

    task automatic check_all_quiet(input string tag);
        check({tag, "_rd_ready"}, rd_ready, '0);
        check({tag, "_wr_ready"}, wr_ready, '0);
        check({tag, "_re"}, bram_re, '0);
        check({tag, "_we"}, bram_we, '0);
        check({tag, "_rsp_valid"}, rd_rsp_valid, '0);
        check({tag, "_rd_addr"}, bram_rd_addr, '0);
    endtask

    // Scoreboard monitor: every response must match the oldest expectation, on its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
            e = sb_q.pop_front();
            tests++;
            fails++;
            $display("FAIL rsp_missing: got none expected valid %b data %0h at cycle %0d", e.oh, e.data, e.due);
        end
        if (rd_rsp_valid != '0) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got valid %b data %0h expected none", rd_rsp_valid, rd_rsp_data);
            end else begin
                e = sb_q.pop_front();
                check("rsp_cycle", cyc, e.due);
                check("rsp_valid", rd_rsp_valid, e.oh);
                check("rsp_data", rd_rsp_data, e.data);
            end
        end
    end

    initial begin
        logic [NR-1:0] oh;
        int            addrs [7];
        rd_valid = '0; rd_addr = '0; wr_valid = '0; wr_addr = '0; wr_data = '0;
        addrs = '{7, 10, 11, 12, 13, 20, 21};

        // Preload while in reset
        for (int i = 0; i < 7; i++) begin
            pl_en = 1'b1; pl_addr = AW'(addrs[i]); pl_data = pat(addrs[i]);
            next_cycle();
        end
        pl_en = 1'b0;

        // Reset state, with every request asserted
        rd_valid = '1; wr_valid = '1;
        sample();
        check_all_quiet("rst");
        rd_valid = '0; wr_valid = '0;
        next_cycle();
        rst_n = 1'b1;

        // 1. Single write then read
        wr_valid = 2'b01; wr_addr[0 +: AW] = 11'd3; wr_data[0 +: DW] = 192'h5A5A;
        sample();
        check("t1_wr_ready", wr_ready, 2'b01);
        check("t1_we", bram_we, 1'b1);
        check("t1_wr_addr", bram_wr_addr, 11'd3);
        check("t1_wr_data", bram_wr_data, 192'h5A5A);
        check("t1_rd_idle", rd_ready, 4'b0000);
        next_cycle();
        wr_valid = '0; rd_valid = 4'b0100; set_rd(2, 11'd3);
        sample();
        check("t1_rd_ready", rd_ready, 4'b0100);
        check("t1_rd_addr", bram_rd_addr, 11'd3);
        expect_rsp(4'b0100, 192'h5A5A);
        next_cycle();
        rd_valid = '0;
        sample();
        next_cycle();

        // Reset pulse to bring both pointers back to 0
        rst_n = 1'b0;
        sample();
        check_all_quiet("rst2");
        next_cycle();
        rst_n = 1'b1;

        // 2. Four readers held valid: 0,1,2,3,0
        rd_valid = 4'b1111;
        for (int i = 0; i < NR; i++) set_rd(i, AW'(10 + i));
        for (int k = 0; k < 5; k++) begin
            sample();
            oh = 4'b0001 << (k % 4);
            check("t2_rd_ready", rd_ready, oh);
            check("t2_rd_addr", bram_rd_addr, AW'(10 + (k % 4)));
            expect_rsp(oh, pat(10 + (k % 4)));
            next_cycle();
        end
        rd_valid = '0;

        // 3. Collision: rd0 and wr1 both at address 7
        rd_valid = 4'b0001; set_rd(0, 11'd7);
        wr_valid = 2'b10; wr_addr[AW +: AW] = 11'd7; wr_data[DW +: DW] = 192'hBEEF;
        sample();
        check("t3_rd_blocked", rd_ready, 4'b0000);
        check("t3_re_blocked", bram_re, 1'b0);
        check("t3_wr_ready", wr_ready, 2'b10);
        check("t3_wr_addr", bram_wr_addr, 11'd7);
        next_cycle();
        wr_valid = '0;
        sample();
        check("t3_rd_retry", rd_ready, 4'b0001);
        check("t3_rd_addr", bram_rd_addr, 11'd7);
        expect_rsp(4'b0001, 192'hBEEF);
        next_cycle();
        rd_valid = '0;

        // 4. Pointer fairness (pointer is 1 here)
        rd_valid = 4'b0010; set_rd(1, 11'd20);
        sample();
        check("t4_rd1_alone", rd_ready, 4'b0010);
        expect_rsp(4'b0010, pat(20));
        next_cycle();
        rd_valid = 4'b0011; set_rd(0, 11'd21);
        sample();
        check("t4_wrap_rd0", rd_ready, 4'b0001);
        expect_rsp(4'b0001, pat(21));
        next_cycle();
        rd_valid = 4'b0010;
        sample();
        check("t4_rd1_again", rd_ready, 4'b0010);
        expect_rsp(4'b0010, pat(20));
        next_cycle();
        rd_valid = '0;

        // 5. Reset mid-read: rd3's response must never appear
        rd_valid = 4'b1000; set_rd(3, 11'd12);
        sample();
        check("t5_rd3_grant", rd_ready, 4'b1000);
        #1;
        rst_n = 1'b0;
        rd_valid = 4'b1111; wr_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            sample();
            check_all_quiet("t5_rst");
            next_cycle();
        end
        rst_n = 1'b1;
        wr_valid = '0;
        for (int i = 0; i < NR; i++) set_rd(i, AW'(10 + i));
        sample();
        check("t5_first_rd0", rd_ready, 4'b0001);
        expect_rsp(4'b0001, pat(10));
        next_cycle();

        // 6. Idle for 20 cycles, then confirm pointers held
        rd_valid = '0;
        sample();
        next_cycle();
        for (int k = 0; k < 20; k++) begin
            sample();
            check("t6_re", bram_re, 1'b0);
            check("t6_we", bram_we, 1'b0);
            check("t6_rsp", rd_rsp_valid, 4'b0000);
            next_cycle();
        end
        rd_valid = 4'b1111;
        wr_valid = 2'b11;
        wr_addr[0 +: AW] = 11'd30; wr_addr[AW +: AW] = 11'd31;
        wr_data[0 +: DW] = 192'h1; wr_data[DW +: DW] = 192'h2;
        sample();
        check("t6_rd_ptr", rd_ready, 4'b0010);
        check("t6_wr_ptr", wr_ready, 2'b01);
        check("t6_wr_addr", bram_wr_addr, 11'd30);
        expect_rsp(4'b0010, pat(11));
        next_cycle();
        rd_valid = '0;
        sample();
        check("t6_wr_next", wr_ready, 2'b10);
        check("t6_wr_addr2", bram_wr_addr, 11'd31);
        next_cycle();
        wr_valid = '0;

        // Drain and confirm every expected response arrived
        for (int k = 0; k < 3; k++) begin
            sample();
            next_cycle();
        end
        check("sb_empty", sb_q.size(), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
